de0_lt24_sopc_cpu_div_cell: RTL

- Iterative 32-cycle restoring divider for the Nios II CPU. It is the inverse-operation companion to the multiplier cell.
- Takes E-stage operands and, on a start pulse, produces quotient and remainder a fixed number of cycles later, holding them for M-stage writeback.
- Signed and unsigned division are supported. All operands are full-width; there is no partial-product split.
- The pipeline stalls on busy and can flush an in-flight division with kill.

---
 rtl/de0_lt24_sopc_cpu_div_cell.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/de0_lt24_sopc_cpu_div_cell.sv
// Iterative restoring divider for the Nios II pipeline: one quotient bit per cycle,
// signed/unsigned, with sign fixup, divide-by-zero reporting and pipeline kill.
module de0_lt24_sopc_cpu_div_cell #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] E_src1,
    input  logic [DATA_WIDTH-1:0] E_src2,
    input  logic                  E_signed,
    input  logic                  E_start,
    input  logic                  M_kill,
    output logic                  M_div_busy,
    output logic                  M_div_done,
    output logic [DATA_WIDTH-1:0] M_div_quot,
    output logic [DATA_WIDTH-1:0] M_div_rem,
    output logic                  M_div_by_zero
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC  = 2'd1,
        ST_FIXUP = 2'd2
    } state_t;

    localparam logic [DATA_WIDTH-1:0] ZERO_W = {DATA_WIDTH{1'b0}};
    localparam logic [DATA_WIDTH-1:0] ONES_W = {DATA_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0]  CNT_LAST = CNT_WIDTH'(DATA_WIDTH - 1);
    localparam logic [CNT_WIDTH-1:0]  CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    // Two's-complement negation, shared by operand magnitude and result fixup.
    function automatic logic [DATA_WIDTH-1:0] negate(input logic [DATA_WIDTH-1:0] v);
        negate = ~v + {{(DATA_WIDTH-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [DATA_WIDTH-1:0] cond_negate(input logic [DATA_WIDTH-1:0] v,
                                                          input logic              neg);
        if (neg) begin
            cond_negate = negate(v);
        end else begin
            cond_negate = v;
        end
    endfunction

    state_t                state_r,    state_s;
    logic [DATA_WIDTH-1:0] dividend_r, dividend_s;   // shifts out dividend, shifts in quotient
    logic [DATA_WIDTH-1:0] divisor_r,  divisor_s;
    logic [DATA_WIDTH-1:0] rem_acc_r,  rem_acc_s;
    logic [CNT_WIDTH-1:0]  cnt_r,      cnt_s;
    logic                  neg_quot_r, neg_quot_s;
    logic                  neg_rem_r,  neg_rem_s;
    logic                  busy_r,     busy_s;
    logic                  done_r,     done_s;
    logic [DATA_WIDTH-1:0] quot_r,     quot_s;
    logic [DATA_WIDTH-1:0] rem_r,      rem_s;
    logic                  by_zero_r,  by_zero_s;

    logic [DATA_WIDTH-1:0] partial_s;
    logic [DATA_WIDTH:0]   diff_s;
    logic                  dvd_neg_s;
    logic                  dvs_neg_s;
    logic                  src2_zero_s;

    // Iteration datapath: the borrow of a W+1-bit subtraction decides each quotient bit.
    always_comb begin
        partial_s   = {rem_acc_r[DATA_WIDTH-2:0], dividend_r[DATA_WIDTH-1]};
        diff_s      = {1'b0, partial_s} - {1'b0, divisor_r};
        dvd_neg_s   = E_signed & E_src1[DATA_WIDTH-1];
        dvs_neg_s   = E_signed & E_src2[DATA_WIDTH-1];
        src2_zero_s = (E_src2 == ZERO_W);
    end

    // Next-state and next-register logic for the IDLE/CALC/FIXUP sequence.
    always_comb begin
        state_s    = state_r;
        dividend_s = dividend_r;
        divisor_s  = divisor_r;
        rem_acc_s  = rem_acc_r;
        cnt_s      = cnt_r;
        neg_quot_s = neg_quot_r;
        neg_rem_s  = neg_rem_r;
        done_s     = 1'b0;
        quot_s     = quot_r;
        rem_s      = rem_r;
        by_zero_s  = by_zero_r;

        case (state_r)
            ST_IDLE: begin
                if (E_start && !M_kill) begin
                    // A zero divisor keeps the raw dividend so the remainder comes out unmodified.
                    if (src2_zero_s) begin
                        dividend_s = E_src1;
                    end else begin
                        dividend_s = cond_negate(E_src1, dvd_neg_s);
                    end
                    divisor_s  = cond_negate(E_src2, dvs_neg_s);
                    rem_acc_s  = ZERO_W;
                    cnt_s      = CNT_LAST;
                    neg_quot_s = dvd_neg_s ^ dvs_neg_s;
                    neg_rem_s  = dvd_neg_s;
                    by_zero_s  = src2_zero_s;
                    state_s    = ST_CALC;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (M_kill) begin
                    state_s = ST_IDLE;
                end else begin
                    if (diff_s[DATA_WIDTH]) begin
                        rem_acc_s  = partial_s;
                        dividend_s = {dividend_r[DATA_WIDTH-2:0], 1'b0};
                    end else begin
                        rem_acc_s  = diff_s[DATA_WIDTH-1:0];
                        dividend_s = {dividend_r[DATA_WIDTH-2:0], 1'b1};
                    end
                    cnt_s = cnt_r - CNT_ONE;
                    if (cnt_r == CNT_ZERO) begin
                        state_s = ST_FIXUP;
                    end else begin
                        state_s = ST_CALC;
                    end
                end
            end
            ST_FIXUP: begin
                if (M_kill) begin
                    state_s = ST_IDLE;
                end else begin
                    if (by_zero_r) begin
                        quot_s = ONES_W;
                        rem_s  = rem_acc_r;
                    end else begin
                        quot_s = cond_negate(dividend_r, neg_quot_r);
                        rem_s  = cond_negate(rem_acc_r, neg_rem_r);
                    end
                    done_s  = 1'b1;
                    state_s = ST_IDLE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        busy_s = (state_s != ST_IDLE);
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= ST_IDLE;
            dividend_r <= ZERO_W;
            divisor_r  <= ZERO_W;
            rem_acc_r  <= ZERO_W;
            cnt_r      <= CNT_ZERO;
            neg_quot_r <= 1'b0;
            neg_rem_r  <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            quot_r     <= ZERO_W;
            rem_r      <= ZERO_W;
            by_zero_r  <= 1'b0;
        end else begin
            state_r    <= state_s;
            dividend_r <= dividend_s;
            divisor_r  <= divisor_s;
            rem_acc_r  <= rem_acc_s;
            cnt_r      <= cnt_s;
            neg_quot_r <= neg_quot_s;
            neg_rem_r  <= neg_rem_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
            quot_r     <= quot_s;
            rem_r      <= rem_s;
            by_zero_r  <= by_zero_s;
        end
    end

    assign M_div_busy    = busy_r;
    assign M_div_done    = done_r;
    assign M_div_quot    = quot_r;
    assign M_div_rem     = rem_r;
    assign M_div_by_zero = by_zero_r;

endmodule
